// File: rtl/flash_pkg.sv
// Shared constants for the flash prefetch path: bus widths and prefetch FSM encodings.
// State codes are plain localparams so every downstream tool sees fixed values.
package flash_pkg;
    localparam int FLASH_ADDR_W = 24;
    localparam int FLASH_DATA_W = 8;

    localparam logic [1:0] PF_IDLE = 2'd0;
    localparam logic [1:0] PF_REQ  = 2'd1;
    localparam logic [1:0] PF_GAP  = 2'd2;
endpackage

// File: rtl/flash_burst_prefetch_if.sv
// Read-request bus between the burst prefetcher (master) and qspi_flash (slave).
interface flash_burst_prefetch_if;
    import flash_pkg::*;

    // Handshake: master raises do_read with a stable addr and holds both until the
    // slave pulses data_ready for one cycle with data valid; do_read drops at that same
    // edge. No request may start while setup_done is low.
    logic                    setup_done;
    logic [FLASH_ADDR_W-1:0] addr;
    logic                    do_read;
    logic                    data_ready;
    logic [FLASH_DATA_W-1:0] data;

    modport master (input setup_done, input data_ready, input data, output addr, output do_read);
    modport slave  (output setup_done, output data_ready, output data, input addr, input do_read);
endinterface

// File: rtl/flash_burst_prefetch_sync_fifo.sv
// Generic synchronous FIFO with flush and occupancy; head word reads as zero when empty.
module sync_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_pop_data,
    output logic [LVL_W-1:0] o_level,
    output logic             o_empty,
    output logic             o_full
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;

    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;
    assign o_empty    = (r_level == '0);
    assign o_full     = (r_level == LVL_W'(DEPTH));
    assign o_level    = r_level;
    assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage carries no reset; the zero-when-empty read mux hides stale words.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end
endmodule

// File: rtl/flash_burst_prefetch.sv
// Burst prefetcher: walks a flash address range one byte at a time into a pop-able FIFO.
// Optional FLASH_PREFETCH_ABORT_EN adds an abort input that cancels the burst and flushes.
module flash_burst_prefetch
    import flash_pkg::*;
#(
    parameter  int FIFO_DEPTH = 8,
    parameter  int LEN_W      = 8,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic [FLASH_ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]        burst_len,
    output logic                    busy,
    output logic                    burst_done,
    flash_burst_prefetch_if.master  flash,
    input  logic                    pop,
    output logic [FLASH_DATA_W-1:0] rd_data,
    output logic                    rd_valid,
    output logic [LVL_W-1:0]        fifo_level,
`ifdef FLASH_PREFETCH_ABORT_EN
    input  logic                    abort,
`endif
    output logic [1:0]              dbg_state
);
    logic [1:0]              r_state,     w_state_nxt;
    logic [FLASH_ADDR_W-1:0] r_cur_addr,  w_cur_addr_nxt;
    logic [LEN_W-1:0]        r_remaining, w_remaining_nxt;
    logic                    r_do_read,   w_do_read_nxt;
    logic                    r_burst_done, w_burst_done_nxt;
    logic                    r_discard,   w_discard_nxt;
    logic                    r_busy;
    logic                    w_push, w_flush, w_abort, w_full, w_empty;

`ifdef FLASH_PREFETCH_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_cur_addr_nxt   = r_cur_addr;
        w_remaining_nxt  = r_remaining;
        w_do_read_nxt    = 1'b0;
        w_burst_done_nxt = 1'b0;
        w_discard_nxt    = r_discard;
        w_push           = 1'b0;
        w_flush          = 1'b0;
        case (r_state)
            PF_IDLE: begin
                if (w_abort) begin
                    w_flush = 1'b1;
                end else if (start && flash.setup_done && (burst_len != '0)) begin
                    w_cur_addr_nxt  = start_addr;
                    w_remaining_nxt = burst_len;
                    if (!w_full) begin
                        w_state_nxt   = PF_REQ;
                        w_do_read_nxt = 1'b1;
                    end else begin
                        w_state_nxt = PF_GAP;
                    end
                end
            end
            PF_REQ: begin
                w_do_read_nxt = 1'b1;
                // An aborted request still completes on the bus; its byte is thrown away.
                if (w_abort) begin
                    w_remaining_nxt = '0;
                    w_flush         = 1'b1;
                    w_discard_nxt   = 1'b1;
                end
                if (flash.data_ready) begin
                    w_do_read_nxt = 1'b0;
                    w_state_nxt   = PF_GAP;
                    if (!(r_discard || w_abort)) begin
                        w_push          = 1'b1;
                        w_cur_addr_nxt  = r_cur_addr + FLASH_ADDR_W'(1);
                        w_remaining_nxt = r_remaining - LEN_W'(1);
                    end
                end
            end
            PF_GAP: begin
                if (w_abort || r_discard) begin
                    w_flush         = w_abort;
                    w_remaining_nxt = '0;
                    w_discard_nxt   = 1'b0;
                    w_state_nxt     = PF_IDLE;
                end else if (r_remaining == '0) begin
                    w_burst_done_nxt = 1'b1;
                    w_state_nxt      = PF_IDLE;
                end else if (!w_full && flash.setup_done) begin
                    w_state_nxt   = PF_REQ;
                    w_do_read_nxt = 1'b1;
                end
            end
            default: w_state_nxt = PF_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= PF_IDLE;
            r_cur_addr   <= '0;
            r_remaining  <= '0;
            r_do_read    <= 1'b0;
            r_burst_done <= 1'b0;
            r_discard    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_addr   <= w_cur_addr_nxt;
            r_remaining  <= w_remaining_nxt;
            r_do_read    <= w_do_read_nxt;
            r_burst_done <= w_burst_done_nxt;
            r_discard    <= w_discard_nxt;
            r_busy       <= (w_state_nxt != PF_IDLE);
        end
    end

    assign flash.addr    = r_cur_addr;
    assign flash.do_read = r_do_read;
    assign busy          = r_busy;
    assign burst_done    = r_burst_done;
    assign dbg_state     = r_state;
    assign rd_valid      = !w_empty;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FLASH_DATA_W)
    ) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .i_push      (w_push),
        .i_push_data (flash.data),
        .i_pop       (pop),
        .i_flush     (w_flush),
        .o_pop_data  (rd_data),
        .o_level     (fifo_level),
        .o_empty     (w_empty),
        .o_full      (w_full)
    );
endmodule
